// File: rtl/mem_arbiter.sv
// Shares one unified word memory between the instruction-fetch and data ports
// of mips_core: data-first arbitration, fetch starvation guard, bus timeout.
module mem_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        halted,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        busy
);

    localparam int SC_W = ($clog2(STARVE_LIM + 1) > 3) ? $clog2(STARVE_LIM + 1) : 3;
    localparam int WC_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIM);
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [SC_W-1:0]   starve_cnt;
    logic [WC_W-1:0]   wait_cnt;
    logic              fetch_ok;
    logic              grant_i;
    logic              grant_d;
    logic              on_bus;
    logic              timeout_hit;
    logic              bus_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst_b) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (grant_d)       next_state = BUS_D;
                          else if (grant_i)  next_state = BUS_I;
            BUS_I, BUS_D: if (bus_done)      next_state = RESP;
            RESP:                            next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before any branch, so no latch can
    // be inferred when a branch leaves it unassigned.
    always_comb begin
        fetch_ok    = i_req & ~halted;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        if (state == IDLE) begin
            // Data wins unless fetch has been passed over STARVE_LIM times.
            if (d_req && !(fetch_ok && starve_cnt == STARVE_MAX)) grant_d = 1'b1;
            else if (fetch_ok)                                    grant_i = 1'b1;
        end
        on_bus      = (state == BUS_I) || (state == BUS_D);
        timeout_hit = on_bus && !m_ack && (wait_cnt == WAIT_LAST);
        bus_done    = on_bus && (m_ack || timeout_hit);
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            bus_err    <= 1'b0;
            busy       <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            i_ack   <= bus_done && (state == BUS_I);
            d_ack   <= bus_done && (state == BUS_D);
            bus_err <= timeout_hit;
            busy    <= (next_state != IDLE);

            if (grant_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                if (fetch_ok && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
            end else if (grant_i) begin
                m_req      <= 1'b1;
                m_we       <= 1'b0;
                m_addr     <= i_addr;
                starve_cnt <= '0;
            end

            if (on_bus && !m_ack) wait_cnt <= wait_cnt + 1'b1;
            else if (state == RESP) wait_cnt <= '0;

            if (bus_done) begin
                m_req <= 1'b0;
                // An aborted transfer returns zero; a completed store keeps d_rdata.
                if (state == BUS_I)
                    i_rdata <= timeout_hit ? '0 : m_rdata;
                else if (timeout_hit || !m_we)
                    d_rdata <= timeout_hit ? '0 : m_rdata;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter and sequencer for the `mips_core`. It shares a single unified word memory between the core's instruction-fetch port and its data (load/store) port. Data accesses have priority, with a starvation guard for fetch. Each access runs as a request/acknowledge transaction, with a timeout that turns a hung memory into a bus error. It sits between `mips_core` and the memory model. The core stalls its PC while a fetch acknowledge is outstanding.

## Interface
- `TIMEOUT`, default 16: maximum cycles in a bus state without `m_ack` before the transaction is aborted (≥1).
- `STARVE_LIM`, default 4: number of consecutive data grants with `i_req` pending, after which fetch wins the next arbitration (≥1).
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `rst_b`, in, 1: reset, synchronous and active-high. `rst_b`=1 at a rising edge resets the block.
- `halted`, in, 1: core halted; blocks new fetch grants.
- `i_req`, in, 1: fetch request.
- `i_addr`, in, 32: fetch address.
- `i_rdata`, out, 32: fetched instruction.
- `i_ack`, out, 1: fetch complete (1-cycle pulse).
- `d_req`, in, 1: data request.
- `d_we`, in, 1: 1 = store, 0 = load.
- `d_addr`, in, 32: data address.
- `d_wdata`, in, 32: store data; byte 0 in [31:24].
- `d_rdata`, out, 32: load data.
- `d_ack`, out, 1: data complete (1-cycle pulse).
- `bus_err`, out, 1: pulses together with `i_ack`/`d_ack` when the transaction timed out.
- `m_req`, out, 1: memory request.
- `m_we`, out, 1: memory write.
- `m_addr`, out, 32: memory address.
- `m_wdata`, out, 32: memory write data.
- `m_rdata`, in, 32: memory read data.
- `m_ack`, in, 1: memory done; valid only while `m_req`=1.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - BUS_I: fetch transaction on the memory bus.
  - BUS_D: data transaction on the memory bus.
  - RESP: acknowledge pulse; no arbitration.
- Requester rule: assert `x_req` and hold the address and data stable until `x_ack`. Requests may change from the cycle after `x_ack`.
- Arbitration in IDLE (fetch is eligible only if `i_req`=1 and `halted`=0):
  - Data only eligible: go to BUS_D.
  - Fetch only eligible: go to BUS_I.
  - Both eligible and `starve_cnt` = `STARVE_LIM`: go to BUS_I.
  - Both eligible otherwise: go to BUS_D.
  - Neither eligible: stay in IDLE.
- On the grant edge, latch `m_addr`, `m_we` (0 for fetch) and `m_wdata` from the winning port, and set `m_req`=1.
- `starve_cnt` (3+ bits, saturating at `STARVE_LIM`):
  - Increments on each BUS_D grant while `i_req`=1 and `halted`=0.
  - Clears on each BUS_I grant.
- BUS_x behaviour:
  - `m_req` is held at 1; `wait_cnt` increments each cycle in which `m_ack`=0.
  - `m_ack`=1: capture `m_rdata` into `i_rdata` (BUS_I) or `d_rdata` (BUS_D load). A store leaves `d_rdata` unchanged. Next state RESP, `m_req`←0.
  - `wait_cnt` = `TIMEOUT`-1 with `m_ack`=0: abort. `m_req`←0, go to RESP with the error flag set; the target rdata register is written with 0.
- RESP: pulse the owner's ack for one cycle; `bus_err`=error flag. Then return to IDLE, clearing `wait_cnt` and the error flag.
- `m_ack` in IDLE or RESP is ignored.
- `halted` rising during BUS_I: the in-flight fetch completes normally.
- Reset mid-transaction: the transaction is abandoned with no ack. `m_req` is 0 in the cycle after the reset edge.

## Timing
- Reset values: state IDLE, `m_req`/`m_we`/`i_ack`/`d_ack`/`bus_err`/`busy` = 0. `m_addr`/`m_wdata`/`i_rdata`/`d_rdata` = 0. `starve_cnt`/`wait_cnt` = 0.
- All outputs are registered; there is no combinational path from any input to any output.
- Best-case latency, with the request first sampled at edge E0:
  - `m_req`=1 in cycle 1.
  - Memory acks in cycle 1.
  - `x_ack` plus data in cycle 2.
  - IDLE in cycle 3.
- A memory ack after k wait cycles gives `x_ack` in cycle 2+k.
- Back-to-back transactions take a minimum of 3 cycles each.
- A timeout gives `x_ack`=`bus_err`=1 in cycle `TIMEOUT`+1.
- Simultaneous `i_req` and `d_req` in IDLE resolve in the same cycle. The loser keeps waiting and is re-arbitrated in the next IDLE.

## Test plan
- Single fetch: `i_addr`=0x0000_0040, memory acks in the first bus cycle with 0x2008_0005. Required: `m_req` in cycle 1 with `m_addr`=0x40 and `m_we`=0; `i_ack`=1 and `i_rdata`=0x2008_0005 in cycle 2; `d_ack` never asserts.
- Contention: `i_req` and `d_req` (store, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF) both asserted at E0. Required: the store goes first with `m_we`=1 and `m_wdata`=0xDEAD_BEEF; `d_ack` in cycle 2; then the fetch is granted, with `i_ack` in cycle 5.
- Starvation, `STARVE_LIM`=4: `i_req` held while `d_req` is re-raised immediately after every `d_ack`. Required: exactly 4 data grants, then a fetch grant, then `starve_cnt`=0.
- Timeout, `TIMEOUT`=16: `m_ack` held at 0 on a load. Required: `m_req` for 16 cycles; then `d_ack`=`bus_err`=1 with `d_rdata`=0; the next transaction completes with `bus_err`=0.
- Halt and reset: with `halted`=1 and `i_req`=1, no grant occurs in 20 cycles while a `d_req` is still served. Assert `rst_b` during BUS_D with a 3-wait-cycle memory. Required: `m_req`=0 after the edge, no `d_ack`, all outputs 0, and `busy`=0.
